// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - tile sequencer for a SIZE x SIZE weight-stationary systolic array
// Loads weights bottom-row first, streams skewed activations, then drains the partial sums.
module systolic_ctrl #(
    parameter int SIZE  = 8,
    parameter int VEC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [VEC_W-1:0]         num_vec,
    input  logic                     abort,
    output logic                     wbuf_rd_en,
    output logic [$clog2(SIZE)-1:0]  wbuf_rd_addr,
    output logic                     weight_load_valid,
    output logic                     abuf_rd_en,
    output logic [VEC_W-1:0]         abuf_rd_addr,
    output logic [SIZE-1:0]          act_valid,
    output logic [SIZE-1:0]          out_valid,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(SIZE);
    localparam int DW = $clog2(2 * SIZE + 1);
    localparam int CW = ((VEC_W > DW) ? VEC_W : DW) + 1;
    localparam logic [CW-1:0] LAST_W  = CW'(SIZE - 1);
    localparam logic [CW-1:0] EXTRA_W = CW'(SIZE);
    localparam logic [CW-1:0] LAST_D  = CW'(2 * SIZE - 1);

    typedef enum logic [2:0] {IDLE, W_LOAD, A_STREAM, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VEC_W-1:0]    nvec_q, nvec_d;
    logic [CW-1:0]       last_a;
    // bit 0 is act_valid[0]; bit SIZE+j is out_valid[j]
    logic [2*SIZE-1:0]   pipe_q, pipe_d;
    logic                wbuf_rd_en_q, wbuf_rd_en_d;
    logic [AW-1:0]       wbuf_rd_addr_q, wbuf_rd_addr_d;
    logic                wlv_q, wlv_d;
    logic                abuf_rd_en_q, abuf_rd_en_d;
    logic [VEC_W-1:0]    abuf_rd_addr_q, abuf_rd_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            nvec_q         <= '0;
            pipe_q         <= '0;
            wbuf_rd_en_q   <= 1'b0;
            wbuf_rd_addr_q <= '0;
            wlv_q          <= 1'b0;
            abuf_rd_en_q   <= 1'b0;
            abuf_rd_addr_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nvec_q         <= nvec_d;
            pipe_q         <= pipe_d;
            wbuf_rd_en_q   <= wbuf_rd_en_d;
            wbuf_rd_addr_q <= wbuf_rd_addr_d;
            wlv_q          <= wlv_d;
            abuf_rd_en_q   <= abuf_rd_en_d;
            abuf_rd_addr_q <= abuf_rd_addr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        nvec_d  = nvec_q;
        last_a  = {{(CW-VEC_W){1'b0}}, nvec_q} - CW'(1);
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (start && !abort) begin
                    state_d = W_LOAD;
                    nvec_d  = num_vec;
                end
            end
            W_LOAD: begin
                // an empty tile holds one extra cycle so the last weight settles before done
                if (nvec_q != '0 && cnt_q == LAST_W) begin
                    state_d = A_STREAM;
                    cnt_d   = '0;
                end else if (nvec_q == '0 && cnt_q == EXTRA_W) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            A_STREAM: begin
                if (cnt_q == last_a) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_D) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        wbuf_rd_en_d   = (state_d == W_LOAD) && (cnt_d <= LAST_W);
        wbuf_rd_addr_d = wbuf_rd_en_d ? AW'(LAST_W - cnt_d) : '0;
        abuf_rd_en_d   = (state_d == A_STREAM);
        abuf_rd_addr_d = abuf_rd_en_d ? cnt_d[VEC_W-1:0] : '0;
        wlv_d          = !abort && wbuf_rd_en_q;
        pipe_d         = abort ? '0 : {pipe_q[2*SIZE-2:0], abuf_rd_en_q};
        busy_d         = (state_d == W_LOAD) || (state_d == A_STREAM) || (state_d == DRAIN);
        done_d         = (state_d == DONE);
    end

    assign wbuf_rd_en        = wbuf_rd_en_q;
    assign wbuf_rd_addr      = wbuf_rd_addr_q;
    assign weight_load_valid = wlv_q;
    assign abuf_rd_en        = abuf_rd_en_q;
    assign abuf_rd_addr      = abuf_rd_addr_q;
    assign act_valid         = pipe_q[SIZE-1:0];
    assign out_valid         = pipe_q[2*SIZE-1:SIZE];
    assign busy              = busy_q;
    assign done              = done_q;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl with SIZE=8, VEC_W=8
module tb_systolic_ctrl;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] num_vec;
    logic       abort;
    logic       wbuf_rd_en;
    logic [2:0] wbuf_rd_addr;
    logic       weight_load_valid;
    logic       abuf_rd_en;
    logic [7:0] abuf_rd_addr;
    logic [7:0] act_valid;
    logic [7:0] out_valid;
    logic       busy;
    logic       done;

    logic [31:0] obs;
    logic [31:0] sb[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    systolic_ctrl #(.SIZE(S), .VEC_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .abort(abort),
        .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr),
        .weight_load_valid(weight_load_valid), .abuf_rd_en(abuf_rd_en),
        .abuf_rd_addr(abuf_rd_addr), .act_valid(act_valid), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign obs = {busy, done, wbuf_rd_en, wbuf_rd_addr, weight_load_valid,
                  abuf_rd_en, abuf_rd_addr, act_valid, out_valid};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // expected outputs in cycle t after the start edge; ab>0 cancels from cycle ab+1
    function automatic logic [31:0] exp_out(input int t, input int nv, input int ab);
        logic       bz, dn, we, wl, ae;
        logic [2:0] wa;
        logic [7:0] aa, av, ov;
        if (ab > 0 && t > ab) return 32'h0;
        we = (t >= 1) && (t <= S);
        wa = we ? 3'(S - t) : 3'd0;
        wl = (t >= 2) && (t <= S + 1);
        ae = (t >= S + 1) && (t <= S + nv);
        aa = ae ? 8'(t - S - 1) : 8'd0;
        for (int i = 0; i < S; i++) begin
            av[i] = (t >= S + 2 + i) && (t <= S + 1 + i + nv);
            ov[i] = (t >= 2*S + 2 + i) && (t <= 2*S + 1 + i + nv);
        end
        bz = (nv > 0) ? (t >= 1 && t <= 3*S + nv) : (t >= 1 && t <= S + 1);
        dn = (t == ((nv > 0) ? 3*S + nv + 1 : S + 2));
        return {bz, dn, we, wa, wl, ae, aa, av, ov};
    endfunction

    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        chk("out", obs, e);
    endtask

    task automatic run_tile(input int nv, input int ab, input int stop_at);
        int tdone;
        int tend;
        tdone = (nv > 0) ? 3*S + nv + 1 : S + 2;
        tend  = (stop_at > 0) ? stop_at : ((ab > 0) ? ab + 3 : tdone);
        start   = 1'b1;
        num_vec = 8'(nv);
        abort   = 1'b0;
        for (int t = 1; t <= tend; t++) sb.push_back(exp_out(t, nv, ab));
        for (int t = 1; t <= tend; t++) begin
            step();
            start   = (t == 4);
            num_vec = 8'($urandom_range(255, 0));
            abort   = (t == ab);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic sa);
        start   = sa;
        abort   = sa;
        num_vec = 8'd5;
        for (int i = 0; i < n; i++) sb.push_back(32'h0);
        for (int i = 0; i < n; i++) step();
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        num_vec = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_tile(4, 0, 0);
        idle_cycles(3, 1'b0);
        run_tile(0, 0, 0);
        idle_cycles(2, 1'b0);
        run_tile(255, 0, 0);
        idle_cycles(2, 1'b0);
        run_tile(3, 0, 0);
        run_tile(2, 0, 0);
        run_tile(4, 0, 0);
        idle_cycles(2, 1'b0);
        run_tile(4, 12, 0);
        idle_cycles(2, 1'b0);
        run_tile(4, 0, 0);
        idle_cycles(2, 1'b0);
        idle_cycles(3, 1'b1);

        run_tile(4, 0, 15);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async", obs, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_tile(4, 0, 0);
        idle_cycles(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
